multi_port_register_file: RTL



---
 rtl/multi_port_register_file_pkg.sv | 12 +
 rtl/multi_port_register_file_if.sv | 35 +++
 rtl/multi_port_register_file_scoreboard.sv | 60 ++++++
 rtl/multi_port_register_file.sv | 68 ++++++
 4 files changed

// File: rtl/multi_port_register_file_pkg.sv
// Shared constants for the integer register file and its busy scoreboard.
// Default geometry matches the 32 x 32-bit architectural register file.
package multi_port_register_file_pkg;

  localparam bit ENABLE  = 1'b1;
  localparam bit DISABLE = 1'b0;

  localparam int ZERO_INDEX    = 0;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 5;

endpackage

// File: rtl/multi_port_register_file_if.sv
// Register file access bus: N read ports, one write port, one reserve port.
// All request signals are level strobes sampled at the rising clock edge; there is no backpressure.
interface multi_port_register_file_if
  import multi_port_register_file_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int READ_PORTS = 2
);
  localparam int NUM_WORDS = 2 ** DEPTH;

  logic [READ_PORTS-1:0]       read_enable;
  logic [READ_PORTS*DEPTH-1:0] read_index;
  logic [READ_PORTS*WIDTH-1:0] read_data;
  logic [READ_PORTS-1:0]       read_busy;
  logic                        write_enable;
  logic [DEPTH-1:0]            write_index;
  logic [WIDTH-1:0]            write_data;
  logic                        reserve_enable;
  logic [DEPTH-1:0]            reserve_index;
  logic [NUM_WORDS-1:0]        busy_vector;

  modport master (
    output read_enable, read_index, write_enable, write_index, write_data,
           reserve_enable, reserve_index,
    input  read_data, read_busy, busy_vector
  );

  modport slave (
    input  read_enable, read_index, write_enable, write_index, write_data,
           reserve_enable, reserve_index,
    output read_data, read_busy, busy_vector
  );

endinterface

// File: rtl/multi_port_register_file_scoreboard.sv
// Per-register busy bits: reserve on issue, release on writeback.
// Lookups are from the registered state only, so a same-cycle writeback does not hide a hazard.
module register_scoreboard
  import multi_port_register_file_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int READ_PORTS = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter int NUM_WORDS  = 2 ** DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        reserve_enable,
  input  logic [DEPTH-1:0]            reserve_index,
  input  logic                        write_enable,
  input  logic [DEPTH-1:0]            write_index,
  input  logic [READ_PORTS-1:0]       read_enable,
  input  logic [READ_PORTS*DEPTH-1:0] read_index,
  output logic [READ_PORTS-1:0]       read_busy,
  output logic [NUM_WORDS-1:0]        busy_vector
);

  logic [NUM_WORDS-1:0] busy_q;
  logic [NUM_WORDS-1:0] busy_d;
  logic                 reserve_accept;

  assign reserve_accept = reserve_enable &&
                          !(ZERO_REG == ENABLE && reserve_index == DEPTH'(ZERO_INDEX));

  // Release first, then reserve: a new producer issued on the writeback cycle stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (write_enable) begin
      busy_d[write_index] = DISABLE;
    end
    if (reserve_accept) begin
      busy_d[reserve_index] = ENABLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    read_busy = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (read_enable[p]) begin
        read_busy[p] = busy_q[read_index[p*DEPTH +: DEPTH]];
      end
    end
  end

  assign busy_vector = busy_q;

endmodule

// File: rtl/multi_port_register_file.sv
// Architectural integer register file: N combinational read ports, one synchronous
// write port, optional hard-wired zero register and optional write-to-read bypass.
module multi_port_register_file
  import multi_port_register_file_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int READ_PORTS = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  multi_port_register_file_if.slave bus
);

  localparam int NUM_WORDS = 2 ** DEPTH;

  logic [WIDTH-1:0] registers [NUM_WORDS];
  logic             write_accept;

  // Gated by reset so nothing is forwarded while the file is held cleared.
  assign write_accept = reset && bus.write_enable &&
                        !(ZERO_REG == ENABLE && bus.write_index == DEPTH'(ZERO_INDEX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        registers[i] <= '0;
      end
    end else if (write_accept) begin
      registers[bus.write_index] <= bus.write_data;
    end
  end

  always_comb begin
    logic [DEPTH-1:0] idx;
    bus.read_data = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      idx = bus.read_index[p*DEPTH +: DEPTH];
      if (bus.read_enable[p] && !(ZERO_REG == ENABLE && idx == DEPTH'(ZERO_INDEX))) begin
        if (BYPASS == ENABLE && write_accept && bus.write_index == idx) begin
          bus.read_data[p*WIDTH +: WIDTH] = bus.write_data;
        end else begin
          bus.read_data[p*WIDTH +: WIDTH] = registers[idx];
        end
      end
    end
  end

  register_scoreboard #(
    .DEPTH      (DEPTH),
    .READ_PORTS (READ_PORTS),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk            (clk),
    .reset          (reset),
    .reserve_enable (bus.reserve_enable),
    .reserve_index  (bus.reserve_index),
    .write_enable   (bus.write_enable),
    .write_index    (bus.write_index),
    .read_enable    (bus.read_enable),
    .read_index     (bus.read_index),
    .read_busy      (bus.read_busy),
    .busy_vector    (bus.busy_vector)
  );

endmodule
